// File: rtl/keycode_conditioner.sv
// Turns raw USB keycodes into a debounced, frame-aligned, auto-repeating motion
// command, a one-shot strike pulse for space, and a synchronized frame tick.
module keycode_conditioner #(
  parameter int unsigned DEBOUNCE     = 16,
  parameter int unsigned REPEAT_DELAY = 15,
  parameter int unsigned REPEAT_RATE  = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [7:0] keycode_out,
  output logic       strike,
  output logic       frame_tick
);

  localparam logic [15:0] DEB_MAX   = 16'(DEBOUNCE - 1);
  localparam logic [5:0]  DLY_LAST  = 6'(REPEAT_DELAY - 1);
  localparam logic [5:0]  RPT_LAST  = 6'(REPEAT_RATE - 1);
  localparam logic [7:0]  KEY_NONE  = 8'h00;
  localparam logic [7:0]  KEY_A     = 8'h04;
  localparam logic [7:0]  KEY_D     = 8'h07;
  localparam logic [7:0]  KEY_S     = 8'h16;
  localparam logic [7:0]  KEY_W     = 8'h1A;
  localparam logic [7:0]  KEY_SPACE = 8'h2C;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    DELAY  = 2'd2,
    REPEAT = 2'd3
  } state_t;

  function automatic logic [7:0] map_key(input logic [7:0] kc);
    case (kc)
      KEY_A, KEY_D, KEY_S, KEY_W, KEY_SPACE: map_key = kc;
      default:                               map_key = KEY_NONE;
    endcase
  endfunction

  function automatic logic is_motion(input logic [7:0] kc);
    case (kc)
      KEY_A, KEY_D, KEY_S, KEY_W: is_motion = 1'b1;
      default:                    is_motion = 1'b0;
    endcase
  endfunction

  logic        s1_r, s2_r, s3_r;
  logic [7:0]  kc_q_r, prev_r, accepted_r, acc_d_r, key_r;
  logic [15:0] deb_cnt_r, deb_cnt_s;
  logic [5:0]  fcnt_r, fcnt_s;
  logic [7:0]  mapped_s, key_s, kout_s;
  logic        accept_s, change_s, press_motion_s, clear_s;
  state_t      state_r, state_s;

  // Three-flop synchronizer for vsync and registered rising-edge tick
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_r       <= 1'b1;
      s2_r       <= 1'b1;
      s3_r       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      s1_r       <= frame_clk;
      s2_r       <= s1_r;
      s3_r       <= s2_r;
      frame_tick <= s2_r & ~s3_r;
    end
  end

  assign mapped_s       = map_key(kc_q_r);
  assign change_s       = accept_s && (mapped_s != accepted_r);
  assign press_motion_s = change_s && is_motion(mapped_s);
  assign clear_s        = change_s && !is_motion(mapped_s);

  // Debounce counter next value; a mismatch on the saturating cycle restarts it
  always_comb begin
    deb_cnt_s = 16'd0;
    accept_s  = 1'b0;
    if (mapped_s == prev_r) begin
      if (deb_cnt_r >= DEB_MAX) begin
        deb_cnt_s = DEB_MAX;
      end else begin
        deb_cnt_s = deb_cnt_r + 16'd1;
      end
      accept_s = (deb_cnt_s == DEB_MAX);
    end else begin
      deb_cnt_s = 16'd0;
      accept_s  = 1'b0;
    end
  end

  // Input register, debounce state, accepted key and strike edge detect
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      kc_q_r     <= 8'h00;
      prev_r     <= 8'h00;
      deb_cnt_r  <= 16'd0;
      accepted_r <= 8'h00;
      acc_d_r    <= 8'h00;
      strike     <= 1'b0;
    end else begin
      kc_q_r    <= keycode;
      prev_r    <= mapped_s;
      deb_cnt_r <= deb_cnt_s;
      if (accept_s) begin
        accepted_r <= mapped_s;
      end else begin
        accepted_r <= accepted_r;
      end
      acc_d_r <= accepted_r;
      strike  <= (accepted_r == KEY_SPACE) && (acc_d_r != KEY_SPACE);
    end
  end

  // Command FSM: key events win over a coincident tick, which then emits 0x00
  always_comb begin
    state_s = state_r;
    key_s   = key_r;
    fcnt_s  = fcnt_r;
    kout_s  = keycode_out;
    if (press_motion_s) begin
      state_s = PEND;
      key_s   = mapped_s;
      if (frame_tick) begin
        kout_s = KEY_NONE;
      end else begin
        kout_s = keycode_out;
      end
    end else if (clear_s) begin
      state_s = IDLE;
      if (frame_tick) begin
        kout_s = KEY_NONE;
      end else begin
        kout_s = keycode_out;
      end
    end else if (frame_tick) begin
      case (state_r)
        IDLE: begin
          kout_s = KEY_NONE;
        end
        PEND: begin
          kout_s  = key_r;
          fcnt_s  = 6'd0;
          state_s = DELAY;
        end
        DELAY: begin
          if (fcnt_r == DLY_LAST) begin
            kout_s  = key_r;
            fcnt_s  = 6'd0;
            state_s = REPEAT;
          end else begin
            kout_s = KEY_NONE;
            fcnt_s = fcnt_r + 6'd1;
          end
        end
        REPEAT: begin
          if (fcnt_r == RPT_LAST) begin
            kout_s = key_r;
            fcnt_s = 6'd0;
          end else begin
            kout_s = KEY_NONE;
            fcnt_s = fcnt_r + 6'd1;
          end
        end
        default: begin
          state_s = IDLE;
          kout_s  = KEY_NONE;
          fcnt_s  = 6'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Command FSM state and registered command output
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= IDLE;
      key_r       <= 8'h00;
      fcnt_r      <= 6'd0;
      keycode_out <= 8'h00;
    end else begin
      state_r     <= state_s;
      key_r       <= key_s;
      fcnt_r      <= fcnt_s;
      keycode_out <= kout_s;
    end
  end

endmodule
